// File: rtl/note_detector_pkg.sv
// Shared note codes, tone frequencies and detector types.
// The frequency table matches the one the tone generator uses.
package note_detector_pkg;

    localparam int NUM_NOTES = 7;
    localparam int CNT_W     = 20;

    typedef enum logic [2:0] {
        NOTE_A    = 3'd0,
        NOTE_B    = 3'd1,
        NOTE_C    = 3'd2,
        NOTE_D    = 3'd3,
        NOTE_E    = 3'd4,
        NOTE_F    = 3'd5,
        NOTE_G    = 3'd6,
        NOTE_NONE = 3'd7
    } note_e;

    typedef enum logic {
        SILENT = 1'b0,
        TRACK  = 1'b1
    } det_state_e;

    function automatic int note_freq(int k);
        unique case (k)
            0:       return 220;
            1:       return 247;
            2:       return 261;
            3:       return 294;
            4:       return 330;
            5:       return 349;
            default: return 392;
        endcase
    endfunction

    function automatic int half_period(int clk_hz, int k);
        return clk_hz / note_freq(k) / 2;
    endfunction

endpackage

// File: rtl/note_detector_if.sv
// Tone receive bundle: square wave in, decoded note and
// measurement out.
interface note_detector_if;
    import note_detector_pkg::*;

    logic               soundWave;
    note_e              note;
    logic               noteValid;
    logic               noteChange;
    logic [CNT_W-1:0]   halfPeriod;

    modport master (
        output soundWave,
        input  note,
        input  noteValid,
        input  noteChange,
        input  halfPeriod
    );

    modport slave (
        input  soundWave,
        output note,
        output noteValid,
        output noteChange,
        output halfPeriod
    );

endinterface

// File: rtl/note_classifier.sv
// Maps a measured half-period to a note code by window compare.
// Windows are disjoint, so at most one note can match.
module note_classifier
    import note_detector_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TOL_CYCLES = 2000
) (
    input  logic [CNT_W-1:0] meas,
    output note_e            cls
);

    localparam int PAD = 32 - CNT_W;

    int m;
    assign m = {{PAD{1'b0}}, meas};

    function automatic logic in_win(int v, int h);
        return (v >= h - TOL_CYCLES) && (v <= h + TOL_CYCLES);
    endfunction

    always_comb begin
        cls = NOTE_NONE;
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (in_win(m, half_period(CLK_HZ, k)))
                cls = note_e'(3'(k));
        end
    end

endmodule

// File: rtl/note_detector.sv
// Measures square-wave half-periods, classifies them and holds
// a debounced note code with timeout back to none.
module note_detector
    import note_detector_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TOL_CYCLES   = 2000,
    parameter int STABLE_COUNT = 4,
    parameter int TIMEOUT      = 250_000
) (
    input  logic            clk,
    input  logic            reset,
    note_detector_if.slave  tone
);

    localparam int MW = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    STAB    = MW'(STABLE_COUNT);

    logic             sync1, sync2, sync3;
    logic             tog;
    logic [CNT_W-1:0] cnt, cnt_n;
    det_state_e       state, state_n;
    note_e            cand, cand_n;
    logic [MW-1:0]    mc, mc_n;
    note_e            note_q, note_n;
    logic             valid_q;
    logic             chg_q, chg_n;
    logic [CNT_W-1:0] hp_q, hp_n;
    note_e            cls;

    assign tog = sync2 != sync3;

    note_classifier #(
        .CLK_HZ     (CLK_HZ),
        .TOL_CYCLES (TOL_CYCLES)
    ) u_cls (
        .meas (cnt),
        .cls  (cls)
    );

    always_comb begin
        state_n = state;
        cand_n  = cand;
        mc_n    = mc;
        note_n  = note_q;
        chg_n   = 1'b0;
        hp_n    = hp_q;
        if (tog)
            cnt_n = CNT_W'(1);
        else if (cnt == CNT_MAX)
            cnt_n = cnt;
        else
            cnt_n = cnt + CNT_W'(1);

        unique case (state)
            SILENT: begin
                if (tog)
                    state_n = TRACK;
            end
            TRACK: begin
                if (tog) begin
                    hp_n = cnt;
                    if (cls == cand) begin
                        if (mc != STAB)
                            mc_n = mc + MW'(1);
                    end else begin
                        cand_n = cls;
                        mc_n   = MW'(1);
                    end
                    if (mc_n == STAB && cand_n != note_q) begin
                        note_n = cand_n;
                        chg_n  = 1'b1;
                    end
                end else if (cnt >= TMO) begin
                    // silence: forget any partial lock
                    state_n = SILENT;
                    note_n  = NOTE_NONE;
                    chg_n   = note_q != NOTE_NONE;
                    cand_n  = NOTE_NONE;
                    mc_n    = '0;
                end
            end
            default: state_n = SILENT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            cnt     <= '0;
            state   <= SILENT;
            cand    <= NOTE_NONE;
            mc      <= '0;
            note_q  <= NOTE_NONE;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            hp_q    <= '0;
        end else begin
            sync1   <= tone.soundWave;
            sync2   <= sync1;
            sync3   <= sync2;
            cnt     <= cnt_n;
            state   <= state_n;
            cand    <= cand_n;
            mc      <= mc_n;
            note_q  <= note_n;
            valid_q <= note_n != NOTE_NONE;
            chg_q   <= chg_n;
            hp_q    <= hp_n;
        end
    end

    assign tone.note       = note_q;
    assign tone.noteValid  = valid_q;
    assign tone.noteChange = chg_q;
    assign tone.halfPeriod = hp_q;

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector at a scaled clock rate, checked
// against an interval-history model of the note lock.
module tb_note_detector;
    import note_detector_pkg::*;

    localparam int CLK_HZ = 250_000;
    localparam int TOL    = 8;
    localparam int STAB   = 4;
    localparam int TMO    = 1200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    note_detector_if ifc ();

    note_detector #(
        .CLK_HZ       (CLK_HZ),
        .TOL_CYCLES   (TOL),
        .STABLE_COUNT (STAB),
        .TIMEOUT      (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tone  (ifc)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                      tag, got, exp, cyc);
    endtask

    // model: notes are fixed by runs of equal classes
    int m_note = 7;
    int m_hp = 0;
    int m_chg = 0;
    bit m_track = 0;
    int m_hist[$];
    int last_tog = 0;

    function automatic int h_of(int k);
        int freqs[7] = '{220, 247, 261, 294, 330, 349, 392};
        return CLK_HZ / freqs[k] / 2;
    endfunction

    function automatic int ref_class(int m);
        for (int k = 0; k < 7; k++) begin
            int d = m - h_of(k);
            if (d < 0) d = -d;
            if (d <= TOL) return k;
        end
        return 7;
    endfunction

    task automatic model_edge(int n);
        int c;
        bit same;
        if (m_track && n > TMO) begin
            if (m_note != 7) m_chg++;
            m_note = 7;
            m_hist.delete();
            m_track = 0;
        end
        if (!m_track) begin
            m_track = 1;
            return;
        end
        m_hp = n;
        c = ref_class(n);
        m_hist.push_back(c);
        if (m_hist.size() > STAB) void'(m_hist.pop_front());
        same = m_hist.size() == STAB;
        foreach (m_hist[i]) if (m_hist[i] != c) same = 0;
        if (same && c != m_note) begin
            m_note = c;
            m_chg++;
        end
    endtask

    int chg_seen = 0;
    int chg_cyc = -1;
    logic rst_q = 1'b1;
    int prev_note = 7;

    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        if (!rst_q && !reset) begin
            check("chg_pulse", int'(ifc.noteChange),
                  int'(int'(ifc.note) != prev_note));
            if (ifc.noteChange) begin
                chg_seen++;
                chg_cyc = cyc;
            end
        end
        prev_note = int'(ifc.note);
    end

    task automatic pulse(int n);
        bit drop;
        int t0;
        drop = m_track && n > TMO && m_note != 7;
        t0 = last_tog;
        repeat (n - 4) @(posedge clk);
        #1 ifc.soundWave = ~ifc.soundWave;
        last_tog = cyc;
        model_edge(n);
        repeat (4) @(posedge clk);
        #1;
        if (drop) check("drop_cyc", chg_cyc, t0 + 3 + TMO);
        check("note", int'(ifc.note), m_note);
        check("valid", int'(ifc.noteValid), int'(m_note != 7));
        check("hp", int'(ifc.halfPeriod), m_hp);
        check("nchg", chg_seen, m_chg);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_note = 7;
        m_hp = 0;
        m_hist.delete();
        m_track = 0;
        check("rst_note", int'(ifc.note), 7);
        check("rst_valid", int'(ifc.noteValid), 0);
        check("rst_chg", int'(ifc.noteChange), 0);
        check("rst_hp", int'(ifc.halfPeriod), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: cycle %0d reached, limit 200000", cyc);
        $fatal(1);
    end

    initial begin
        int k, run, n;
        ifc.soundWave = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("init_note", int'(ifc.note), 7);
        check("init_valid", int'(ifc.noteValid), 0);
        check("init_chg", int'(ifc.noteChange), 0);
        check("init_hp", int'(ifc.halfPeriod), 0);

        repeat (5) pulse(h_of(0) + 1);
        check("lock_a", int'(ifc.note), 0);

        for (int j = 0; j < 7; j++)
            repeat (5) pulse(h_of(j) + $urandom_range(0, 2 * TOL) - TOL);

        repeat (5) pulse(h_of(4) + 1);
        pulse(200);
        repeat (3) pulse(h_of(4) + 1);
        check("glitch_e", int'(ifc.note), 4);

        repeat (5) pulse(h_of(6));
        pulse(TMO + 300);
        check("tmo_note", int'(ifc.note), 7);
        repeat (5) pulse(h_of(6));
        pulse(TMO);
        check("tmo_edge", int'(ifc.note), 6);

        repeat (4) pulse(400);
        repeat (4) pulse(h_of(5) + TOL);
        check("f_hi_in", int'(ifc.note), 5);
        repeat (4) pulse(h_of(5) + TOL + 1);
        check("f_hi_out", int'(ifc.note), 7);
        repeat (4) pulse(h_of(5) - TOL);
        repeat (4) pulse(h_of(5) - TOL - 1);

        repeat (5) pulse(h_of(2));
        if (ifc.soundWave) pulse(h_of(2));
        do_reset();
        repeat (4) pulse(h_of(2));
        check("relock_wait", int'(ifc.note), 7);
        pulse(h_of(2));
        check("relock_c", int'(ifc.note), 2);

        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 7);
            run = $urandom_range(1, 6);
            repeat (run) begin
                if ($urandom_range(0, 19) == 0)
                    n = TMO + $urandom_range(0, 40);
                else if (k == 7)
                    n = $urandom_range(100, 1300);
                else
                    n = h_of(k) + $urandom_range(0, 2 * TOL + 2) - TOL - 1;
                pulse(n);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
